// File: rtl/pla_pkg.sv
// Shared constants for the piecewise-linear sigmoid/tanh unit.
// Breakpoints use 3 fraction bits and offsets use 5; both are rescaled to the datapath inside the modules.
package pla_pkg;

  typedef enum logic {
    PLA_SIGMOID = 1'b0,
    PLA_TANH    = 1'b1
  } pla_mode_e;

  // Breakpoints 1, 2.375 and 5 in units of 2^-3
  localparam int BP_FRAC = 3;
  localparam int BP_ONE  = 8;
  localparam int BP_MID  = 19;
  localparam int BP_SAT  = 40;

  // Slopes 1/4, 1/8 and 1/32 as right-shift amounts
  localparam int SH_LO  = 2;
  localparam int SH_MID = 3;
  localparam int SH_HI  = 5;

  // Offsets 0.5, 0.625 and 0.84375 in units of 2^-5
  localparam int OFS_FRAC = 5;
  localparam int OFS_LO   = 16;
  localparam int OFS_MID  = 20;
  localparam int OFS_HI   = 27;

endpackage

// File: rtl/pla_segment.sv
// Combinational base-sigmoid segment map s(a) for a = |z| >= 0, shift-and-add only.
// a and s are unsigned fixed-point with FI fraction bits; s lies in [0.5, 1.0].
module pla_segment
  import pla_pkg::*;
#(
  parameter int WI = 17,
  parameter int FI = 11
) (
  input  logic [WI-1:0] a,
  output logic [WI-1:0] s
);

  localparam logic [WI-1:0] BP1   = WI'(BP_ONE) << (FI - BP_FRAC);
  localparam logic [WI-1:0] BP2   = WI'(BP_MID) << (FI - BP_FRAC);
  localparam logic [WI-1:0] BP5   = WI'(BP_SAT) << (FI - BP_FRAC);
  localparam logic [WI-1:0] OF_LO = WI'(OFS_LO) << (FI - OFS_FRAC);
  localparam logic [WI-1:0] OF_MD = WI'(OFS_MID) << (FI - OFS_FRAC);
  localparam logic [WI-1:0] OF_HI = WI'(OFS_HI) << (FI - OFS_FRAC);
  localparam logic [WI-1:0] ONE   = WI'(1) << FI;

  // The datapath carries 5 extra fraction bits, so a >> 5 never loses precision
  always_comb begin
    if (a >= BP5) begin
      s = ONE;
    end else if (a >= BP2) begin
      s = (a >> SH_HI) + OF_HI;
    end else if (a >= BP1) begin
      s = (a >> SH_MID) + OF_MD;
    end else begin
      s = (a >> SH_LO) + OF_LO;
    end
  end

endmodule

// File: rtl/pla_activation.sv
// Streaming PLA sigmoid/tanh, 3-stage pipeline; a result is valid 3 cycles after the input is presented.
// Elastic valid/ready: a stage loads when empty or when its successor loads. PLA_ROUND_EN selects round-to-nearest.
module pla_activation
  import pla_pkg::*;
#(
  parameter int W_IN  = 10,
  parameter int IN_I  = 4,
  parameter int W_OUT = 10,
  parameter int OUT_I = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [W_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out_data
);

  localparam int F    = W_IN - IN_I;
  localparam int G    = W_OUT - OUT_I;
  localparam int FI   = F + 5;
  localparam int WI   = IN_I + 2 + FI;
  localparam int DROP = FI - G;

  localparam logic signed [WI-1:0] ONE    = WI'(1) << FI;
  localparam logic signed [WI-1:0] SAT_HI = WI'((1 << (W_OUT - 1)) - 1);
  localparam logic signed [WI-1:0] SAT_LO = ~SAT_HI;
`ifdef PLA_ROUND_EN
  localparam logic signed [WI-1:0] HALF   = WI'(1) << (DROP - 1);
`endif

  typedef struct packed {
    pla_mode_e       mode;
    logic            neg;
    logic [WI-1:0]   mag;
  } s1_t;

  typedef struct packed {
    pla_mode_e       mode;
    logic            neg;
    logic [WI-1:0]   s;
  } s2_t;

  logic s1_vld, s2_vld, s3_vld;
  logic ld1, ld2, ld3;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;

  assign ld3       = !s3_vld || out_ready;
  assign ld2       = !s2_vld || ld3;
  assign ld1       = !s1_vld || ld2;
  assign in_ready  = ld1;
  assign out_valid = s3_vld;

  // S1: two extra integer bits keep 2x and |x| in range for the most negative input
  logic signed [WI-1:0] x_ext, z;

  always_comb begin
    x_ext      = {{2{in_data[W_IN-1]}}, in_data, 5'b0};
    z          = (pla_mode_e'(in_mode) == PLA_TANH) ? (x_ext <<< 1) : x_ext;
    s1_d.mode  = pla_mode_e'(in_mode);
    s1_d.neg   = z[WI-1];
    s1_d.mag   = z[WI-1] ? -z : z;
  end

  // S2: segment select and shift-add
  logic [WI-1:0] seg_s;

  pla_segment #(
    .WI (WI),
    .FI (FI)
  ) u_seg (
    .a (s1_q.mag),
    .s (seg_s)
  );

  always_comb begin
    s2_d.mode = s1_q.mode;
    s2_d.neg  = s1_q.neg;
    s2_d.s    = seg_s;
  end

  // S3: reflect, tanh = 2s - 1, then drop fraction bits and saturate
  logic signed [WI-1:0] refl, y, yr, q;
  logic [W_OUT-1:0]     y_out;

  always_comb begin
    refl = s2_q.neg ? (ONE - signed'(s2_q.s)) : signed'(s2_q.s);
    y    = (s2_q.mode == PLA_TANH) ? ((refl <<< 1) - ONE) : refl;
`ifdef PLA_ROUND_EN
    yr   = y + HALF;
`else
    yr   = y;
`endif
    q    = yr >>> DROP;
    if (q > SAT_HI) begin
      y_out = SAT_HI[W_OUT-1:0];
    end else if (q < SAT_LO) begin
      y_out = SAT_LO[W_OUT-1:0];
    end else begin
      y_out = q[W_OUT-1:0];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s3_vld   <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      out_data <= '0;
    end else begin
      if (ld1) begin
        s1_vld <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (ld2) begin
        s2_vld <= s1_vld;
        if (s1_vld) s2_q <= s2_d;
      end
      if (ld3) begin
        s3_vld <= s2_vld;
        if (s2_vld) out_data <= y_out;
      end
    end
  end

endmodule

// File: tb/tb_pla_activation.sv
// Directed vector table plus stall, streaming and reset sequences for pla_activation.
module tb_pla_activation;

  logic       clock = 1'b0;
  logic       resetn;
  logic       in_valid, in_ready, in_mode;
  logic [9:0] in_data;
  logic       out_valid, out_ready;
  logic [9:0] out_data;

  int total = 0;
  int bad   = 0;

`ifdef PLA_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  always #5 clock = ~clock;

  pla_activation dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    logic       mode;
    logic [9:0] x;
    int         expv;
  } vec_t;

  vec_t       tbl [18];
  logic [9:0] fill [4];
  logic [9:0] vx [128];
  logic       vm [128];
  int         exp_q [$];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Real-valued reference; all breakpoints and slopes are exact binary fractions
  function automatic int model(input logic m, input logic [9:0] x);
    real xr, z, a, s, y, v;
    int  r;
    xr = $itor($signed(x)) / 64.0;
    z  = m ? 2.0 * xr : xr;
    a  = (z < 0.0) ? -z : z;
    if (a >= 5.0)        s = 1.0;
    else if (a >= 2.375) s = a / 32.0 + 0.84375;
    else if (a >= 1.0)   s = a / 8.0 + 0.625;
    else                 s = a / 4.0 + 0.5;
    if (z < 0.0) s = 1.0 - s;
    y = m ? 2.0 * s - 1.0 : s;
    v = y * 256.0;
    if (RND) v = v + 0.5;
    r = $rtoi($floor(v));
    if (r > 511)  r = 511;
    if (r < -512) r = -512;
    return r;
  endfunction

  // Called at posedge+1; presents one sample and measures cycles to out_valid
  task automatic run_one(input logic m, input logic [9:0] x, input int expv, input string nm);
    int lat;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = x;
    #4;
    chk({nm, "_rdy"}, int'(in_ready), 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, 3);
    chk({nm, "_dat"}, int'($signed(out_data)), expv);
  endtask

  initial begin
    int   sent, got, stall_left;
    bit   stall_done, acc;
    logic [9:0] held;

    tbl[0]  = '{1'b0, 10'h000, 128};
    tbl[1]  = '{1'b0, 10'h040, 192};
    tbl[2]  = '{1'b0, 10'h3C0, 64};
    tbl[3]  = '{1'b0, 10'h200, 0};
    tbl[4]  = '{1'b1, 10'h040, 192};
    tbl[5]  = '{1'b1, 10'h2C0, -256};
    tbl[6]  = '{1'b1, 10'h000, 0};
    tbl[7]  = '{1'b0, 10'h098, 235};
    tbl[8]  = '{1'b0, 10'h0C4, RND ? 241 : 240};
    tbl[9]  = '{1'b0, 10'h13F, RND ? 256 : 255};
    tbl[10] = '{1'b0, 10'h140, 256};
    tbl[11] = '{1'b0, 10'h03F, 191};
    tbl[12] = '{1'b0, 10'h097, RND ? 236 : 235};
    tbl[13] = '{1'b0, 10'h368, 21};
    tbl[14] = '{1'b1, 10'h1FF, 256};
    tbl[15] = '{1'b1, 10'h3E0, -128};
    tbl[16] = '{1'b1, 10'h030, 160};
    tbl[17] = '{1'b1, 10'h04C, 214};

    fill[0] = 10'h040;
    fill[1] = 10'h3C0;
    fill[2] = 10'h000;
    fill[3] = 10'h0C4;

    // Sweep -8.0 .. +7.75 in 0.25 steps, alternating mode every sample
    for (int i = 0; i < 128; i++) begin
      vx[i] = 10'(-512 + 16 * (i >> 1));
      vm[i] = i[0];
    end

    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_vld", int'(out_valid), 0);
    chk("rst_dat", int'(out_data), 0);
    resetn = 1'b1;
    #4;
    chk("rst_rdy", int'(in_ready), 1);
    @(posedge clock); #1;

    for (int i = 0; i < 18; i++) begin
      run_one(tbl[i].mode, tbl[i].x, tbl[i].expv, $sformatf("vec%0d", i));
    end
    repeat (2) @(posedge clock);
    #1;

    // Streaming with a 4-cycle output stall once the pipeline is in steady state
    sent = 0;
    got = 0;
    stall_left = 0;
    stall_done = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 2000 && got < 128; cyc++) begin
      if (!stall_done && got == 20) begin
        stall_left = 4;
        stall_done = 1'b1;
      end
      out_ready = (stall_left == 0);
      if (sent < 128) begin
        in_valid = 1'b1;
        in_mode  = vm[sent];
        in_data  = vx[sent];
      end else begin
        in_valid = 1'b0;
      end
      #4;
      if (stall_left > 0) begin
        chk("stall_vld", int'(out_valid), 1);
        if (stall_left == 4) held = out_data;
        else chk("stall_dat", int'(out_data), int'(held));
        if (stall_left == 1) begin
          chk("stall_rdy", int'(in_ready), 0);
          chk("stall_inflight", sent - got, 3);
        end
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_spurious", 1, 0);
        end else begin
          chk($sformatf("stream%0d", got), int'($signed(out_data)), exp_q.pop_front());
        end
        got++;
      end
      @(posedge clock); #1;
      if (acc) begin
        exp_q.push_back(model(vm[sent], vx[sent]));
        sent++;
      end
      if (stall_left > 0) stall_left--;
    end
    in_valid = 1'b0;
    chk("stream_count", got, 128);

    // Fill an empty pipeline with output blocked, then reset with 3 samples in flight
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_data  = fill[k];
      #4;
      chk($sformatf("fill_rdy%0d", k), int'(in_ready), (k < 3) ? 1 : 0);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    chk("fill_vld", int'(out_valid), 1);
    chk("fill_dat", int'($signed(out_data)), model(1'b0, fill[0]));
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_vld", int'(out_valid), 0);
    chk("arst_dat", int'(out_data), 0);
    @(posedge clock); #1;
    resetn    = 1'b1;
    out_ready = 1'b1;
    #4;
    chk("rel_rdy", int'(in_ready), 1);
    @(posedge clock); #1;
    for (int k = 0; k < 4; k++) begin
      chk("rel_quiet", int'(out_valid), 0);
      @(posedge clock); #1;
    end
    run_one(1'b1, 10'h040, 192, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
